mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates one shared single-port RAM between the instruction-fetch port (IF) and the memory-access stage data port (D). It issues at most one RAM access per cycle and gives D priority, with a starvation guard for IF. It also tracks in-flight reads so that returning RAM data is routed to the requester that issued it. It sits between the fetch/memory-access stages and the RAM instance.

## Interface
- DATA_W, 64, data width (matches `CPU_WIDTH`)
- ADDR_W, 64, address width
- RAM_LAT, 2, cycles from issue to valid `ram_rdata_i`; legal range 1..4
- STARVE_MAX, 3, consecutive denied IF cycles before IF is forced to win; ≥1
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- if_req_i  in  1  IF read request; held until granted
- if_addr_i  in  ADDR_W  IF read address
- if_gnt_o  out  1  IF request accepted this cycle
- if_rvalid_o  out  1  IF read data valid
- if_rdata_o  out  DATA_W  IF read data
- d_req_i  in  1  D request; held until granted
- d_we_i  in  1  1 = store, 0 = load
- d_func3_i  in  3  access size/sign; passed through to RAM
- d_addr_i  in  ADDR_W  D address
- d_wdata_i  in  DATA_W  store data
- d_gnt_o  out  1  D request accepted this cycle
- d_rvalid_o  out  1  D load data valid
- d_rdata_o  out  DATA_W  D load data
- ram_en_o  out  1  RAM access issued this cycle
- ram_we_o  out  1  RAM write
- ram_func3_o  out  3  RAM func3 (IF issues use 3'b010)
- ram_addr_o  out  ADDR_W  RAM address
- ram_wdata_o  out  DATA_W  RAM write data
- ram_rdata_i  in  DATA_W  RAM read data, valid RAM_LAT cycles after issue

## Operation
- Grant is combinational from the requests and `starve_cnt`. At most one of `if_gnt_o`/`d_gnt_o` is high in a cycle.
- Only D requests: D is granted. Only IF requests: IF is granted. Neither: no grant, `ram_en_o`=0.
- Both request: D wins unless `starve_cnt == STARVE_MAX`, in which case IF wins.
- `starve_cnt` (width ≥ clog2(STARVE_MAX+1)):
  - +1 on a clock edge where `if_req_i && !if_gnt_o`, saturating at STARVE_MAX.
  - Cleared to 0 when `if_gnt_o`, or when `!if_req_i`.
- RAM outputs follow the winner in the grant cycle:
  - `ram_en_o`=1.
  - IF winner: `ram_we_o`=0, `ram_func3_o`=3'b010, `ram_wdata_o`=0.
  - D winner: all RAM fields from D inputs.
  - No grant: all RAM outputs 0.
- Tag pipeline has RAM_LAT stages. Each stage holds {valid, owner}.
  - Stage 0 loads valid = grant && !ram_we_o, owner = IF/D. The pipe shifts every cycle.
  - Stores never create a tag and never produce rvalid; a store completes in its grant cycle.
- Return path (combinational from the last stage):
  - Last stage valid and owner IF: `if_rvalid_o`=1 and `if_rdata_o`=`ram_rdata_i`; D outputs stay 0.
  - Last stage valid and owner D: `d_rvalid_o`=1 and `d_rdata_o`=`ram_rdata_i`; IF outputs stay 0.
  - Otherwise both rvalids and both rdatas are 0.
- Requesters must keep addr/data/we/func3 stable while req is high and not granted. The arbiter does not latch request fields.
- Dropping a request before grant is legal. It is ignored and clears `starve_cnt` if it is IF.

## Timing
- Grant latency: 0 cycles. A request seen in cycle T with a win is granted in T, and the RAM is driven in T.
- Read return: rvalid for a load granted in T is high for exactly one cycle, T+RAM_LAT.
- Throughput: one issue per cycle. Back-to-back reads from mixed owners return in issue order, one per cycle.
- Reset (`rst_n_i`=0, asynchronous):
  - All tags invalid; `starve_cnt`=0.
  - All outputs forced to 0 immediately, including grants and `ram_en_o`.
  - Reads in flight when reset asserts are dropped. No rvalid appears after reset deasserts.
- First grant is possible in the first cycle with `rst_n_i`=1.
- Boundaries:
  - The `starve_cnt` saturating edge and an IF grant in the same cycle: the clear wins.
  - When D is continuously requesting, IF waits at most STARVE_MAX cycles before being granted.
  - A simultaneous store grant and read return: both occur; the return is unaffected.

## Test plan
- Reset mid-flight: IF read at addr 0x10 granted at T; `rst_n_i` pulsed low at T+1 → no `if_rvalid_o` ever. All outputs read 0 during reset.
- Single IF read: 0x100 holding 0xDEAD_BEEF, RAM_LAT=2, grant at T → `if_rvalid_o`=1 at T+2 only, `if_rdata_o`=0xDEAD_BEEF. `d_rvalid_o` stays 0.
- Priority: both request every cycle, STARVE_MAX=3 → D granted at T..T+2, IF at T+3, D at T+4; `starve_cnt` returns to 0 after T+3.
- Store then load: D stores 0x1234 to 0x200 (func3=011) at T, loads 0x200 at T+1 → `d_rvalid_o` at T+1+RAM_LAT with 0x1234. No rvalid at T+RAM_LAT.
- Interleaved routing: IF read at T, D load at T+1, IF read at T+2 → rvalids at T+2 (IF), T+3 (D), T+4 (IF) with the correct data. Rvalids are never both high.
- IF drops its request after 2 denied cycles, then re-requests → counter restarts from 0. IF waits a full STARVE_MAX cycles again.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port RAM between instruction fetch and data ports
// D has priority; an IF starvation counter forces IF through, and a tag pipe routes read returns.
module mem_port_arbiter #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 64,
  parameter int RAM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [2:0]        d_func3_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [2:0]        ram_func3_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0]   starve_q, starve_d;
  logic [RAM_LAT-1:0] tag_v_q, tag_v_d;
  logic [RAM_LAT-1:0] tag_own_q, tag_own_d;  // 1 = D owns the read
  logic               if_win, d_win;

  // Grants are gated by reset so every output drops the moment reset asserts.
  always_comb begin
    if_win = 1'b0;
    d_win  = 1'b0;
    if (rst_n_i) begin
      if (d_req_i && !(if_req_i && (starve_q == CNT_MAX))) begin
        d_win = 1'b1;
      end else if (if_req_i) begin
        if_win = 1'b1;
      end
    end
  end

  assign if_gnt_o = if_win;
  assign d_gnt_o  = d_win;

  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_func3_o = 3'b000;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (d_win) begin
      ram_en_o    = 1'b1;
      ram_we_o    = d_we_i;
      ram_func3_o = d_func3_i;
      ram_addr_o  = d_addr_i;
      ram_wdata_o = d_wdata_i;
    end else if (if_win) begin
      ram_en_o    = 1'b1;
      ram_func3_o = 3'b010;
      ram_addr_o  = if_addr_i;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!if_req_i || if_win) begin
      starve_d = '0;
    end else if (starve_q != CNT_MAX) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_comb begin
    tag_v_d   = '0;
    tag_own_d = '0;
    for (int i = RAM_LAT - 1; i > 0; i--) begin
      tag_v_d[i]   = tag_v_q[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end
    tag_v_d[0]   = if_win || (d_win && !d_we_i);
    tag_own_d[0] = d_win;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      starve_q  <= '0;
      tag_v_q   <= '0;
      tag_own_q <= '0;
    end else begin
      starve_q  <= starve_d;
      tag_v_q   <= tag_v_d;
      tag_own_q <= tag_own_d;
    end
  end

  always_comb begin
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    d_rvalid_o  = 1'b0;
    d_rdata_o   = '0;
    if (tag_v_q[RAM_LAT-1]) begin
      if (tag_own_q[RAM_LAT-1]) begin
        d_rvalid_o = 1'b1;
        d_rdata_o  = ram_rdata_i;
      end else begin
        if_rvalid_o = 1'b1;
        if_rdata_o  = ram_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
// A behavioural RAM with two-cycle read latency sits behind the arbiter.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [63:0] if_rdata;
  logic        d_req, d_we;
  logic [2:0]  d_func3;
  logic [63:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [63:0] d_rdata;
  logic        ram_en, ram_we;
  logic [2:0]  ram_func3;
  logic [63:0] ram_addr, ram_wdata, ram_rdata;

  logic [63:0] mem [logic [63:0]];
  logic [63:0] rd_pipe0, rd_pipe1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .DATA_W(64), .ADDR_W(64), .RAM_LAT(2), .STARVE_MAX(3)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_func3_i(d_func3), .d_addr_i(d_addr),
    .d_wdata_i(d_wdata), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_func3_o(ram_func3),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  // Behavioural RAM: write at the issue edge, read data appears two cycles after issue.
  always @(posedge clk) begin
    rd_pipe1 <= rd_pipe0;
    if (ram_en && !ram_we) begin
      rd_pipe0 <= mem.exists(ram_addr) ? mem[ram_addr] : 64'h0;
    end else begin
      rd_pipe0 <= 64'h0;
    end
    if (ram_en && ram_we) mem[ram_addr] = ram_wdata;
  end
  assign ram_rdata = rd_pipe1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req  = 1'b0;
    if_addr = 64'h0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_func3 = 3'b000;
    d_addr  = 64'h0;
    d_wdata = 64'h0;
  endtask

  initial begin
    rd_pipe0 = 64'h0;
    rd_pipe1 = 64'h0;
    mem[64'h10]  = 64'h55;
    mem[64'h100] = 64'hDEAD_BEEF;
    mem[64'h300] = 64'hA1;
    mem[64'h308] = 64'hB2;
    mem[64'h310] = 64'hC3;

    // Reset with both requests pending: everything must read 0.
    rst_n   = 1'b0;
    idle_inputs();
    if_req  = 1'b1;
    d_req   = 1'b1;
    d_addr  = 64'h44;
    if_addr = 64'h10;
    tick(); tick();
    check("rst_if_gnt", {63'h0, if_gnt}, 64'h0);
    check("rst_d_gnt", {63'h0, d_gnt}, 64'h0);
    check("rst_ram_en", {63'h0, ram_en}, 64'h0);
    check("rst_ram_addr", ram_addr, 64'h0);
    check("rst_if_rvalid", {63'h0, if_rvalid}, 64'h0);
    idle_inputs();
    rst_n = 1'b1;

    // Reset mid-flight: IF read issued, reset pulsed the next cycle, no return ever.
    tick();
    if_req = 1'b1; if_addr = 64'h10; #1;
    check("mf_if_gnt", {63'h0, if_gnt}, 64'h1);
    check("mf_ram_func3", {61'h0, ram_func3}, 64'h2);
    check("mf_ram_addr", ram_addr, 64'h10);
    tick();
    idle_inputs(); #1;
    rst_n = 1'b0; #1;
    check("mf_rst_ram_en", {63'h0, ram_en}, 64'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("mf_no_if_rvalid", {63'h0, if_rvalid}, 64'h0);
      check("mf_no_d_rvalid", {63'h0, d_rvalid}, 64'h0);
      tick();
    end

    // Single IF read returns at T+2 only.
    if_req = 1'b1; if_addr = 64'h100; #1;
    check("ifr_gnt", {63'h0, if_gnt}, 64'h1);
    check("ifr_ram_we", {63'h0, ram_we}, 64'h0);
    tick();
    idle_inputs(); #1;
    check("ifr_t1_rvalid", {63'h0, if_rvalid}, 64'h0);
    tick(); #1;
    check("ifr_t2_rvalid", {63'h0, if_rvalid}, 64'h1);
    check("ifr_t2_rdata", if_rdata, 64'hDEAD_BEEF);
    check("ifr_t2_d_rvalid", {63'h0, d_rvalid}, 64'h0);
    tick(); #1;
    check("ifr_t3_rvalid", {63'h0, if_rvalid}, 64'h0);

    // Priority with starvation guard: IF wins every fourth cycle.
    tick();
    for (int i = 0; i < 8; i++) begin
      if_req = 1'b1; if_addr = 64'h10;
      d_req = 1'b1; d_we = 1'b1; d_func3 = 3'b011; d_addr = 64'h400; d_wdata = 64'h7;
      #1;
      check($sformatf("pri_if_gnt_%0d", i), {63'h0, if_gnt}, (i == 3 || i == 7) ? 64'h1 : 64'h0);
      check($sformatf("pri_d_gnt_%0d", i), {63'h0, d_gnt}, (i == 3 || i == 7) ? 64'h0 : 64'h1);
      if (i == 3) begin
        check("pri_if_we", {63'h0, ram_we}, 64'h0);
        check("pri_if_wdata", ram_wdata, 64'h0);
      end
      tick();
    end
    idle_inputs();
    tick(); tick(); tick();

    // Store then load to the same address.
    d_req = 1'b1; d_we = 1'b1; d_func3 = 3'b011; d_addr = 64'h200; d_wdata = 64'h1234; #1;
    check("st_d_gnt", {63'h0, d_gnt}, 64'h1);
    check("st_ram_we", {63'h0, ram_we}, 64'h1);
    check("st_ram_func3", {61'h0, ram_func3}, 64'h3);
    check("st_ram_wdata", ram_wdata, 64'h1234);
    tick();
    d_we = 1'b0; d_wdata = 64'h0; #1;
    check("ld_d_gnt", {63'h0, d_gnt}, 64'h1);
    check("ld_ram_we", {63'h0, ram_we}, 64'h0);
    tick();
    idle_inputs(); #1;
    check("st_no_rvalid", {63'h0, d_rvalid}, 64'h0);
    tick(); #1;
    check("ld_rvalid", {63'h0, d_rvalid}, 64'h1);
    check("ld_rdata", d_rdata, 64'h1234);
    tick();

    // Interleaved routing, with a store issued alongside the D return.
    if_req = 1'b1; if_addr = 64'h300; #1;
    check("il_if_gnt0", {63'h0, if_gnt}, 64'h1);
    tick();
    idle_inputs(); d_req = 1'b1; d_addr = 64'h308; #1;
    check("il_d_gnt1", {63'h0, d_gnt}, 64'h1);
    tick();
    idle_inputs(); if_req = 1'b1; if_addr = 64'h310; #1;
    check("il_if_gnt2", {63'h0, if_gnt}, 64'h1);
    check("il_t2_if_rvalid", {63'h0, if_rvalid}, 64'h1);
    check("il_t2_if_rdata", if_rdata, 64'hA1);
    check("il_t2_d_rvalid", {63'h0, d_rvalid}, 64'h0);
    tick();
    idle_inputs(); d_req = 1'b1; d_we = 1'b1; d_addr = 64'h500; d_wdata = 64'h9; #1;
    check("il_st_gnt3", {63'h0, d_gnt}, 64'h1);
    check("il_t3_d_rvalid", {63'h0, d_rvalid}, 64'h1);
    check("il_t3_d_rdata", d_rdata, 64'hB2);
    check("il_t3_if_rvalid", {63'h0, if_rvalid}, 64'h0);
    tick();
    idle_inputs(); #1;
    check("il_t4_if_rvalid", {63'h0, if_rvalid}, 64'h1);
    check("il_t4_if_rdata", if_rdata, 64'hC3);
    check("il_t4_d_rvalid", {63'h0, d_rvalid}, 64'h0);
    tick(); tick(); tick();

    // IF drops after two denials; the counter restarts and IF waits three full cycles.
    for (int i = 0; i < 7; i++) begin
      d_req = 1'b1; d_we = 1'b1; d_addr = 64'h400; d_wdata = 64'h1;
      if_req = (i != 2); if_addr = 64'h10;
      #1;
      check($sformatf("drop_if_gnt_%0d", i), {63'h0, if_gnt}, (i == 6) ? 64'h1 : 64'h0);
      tick();
    end
    idle_inputs();
    tick(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
